// File: rtl/divclk_meter_pkg.sv
// Shared types and constants for the divided-clock period meter.
package divclk_meter_pkg;

  localparam int DEF_CNT_W  = 27;
  localparam int REF_CLK_HZ = 60_000_000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_MEASURE = 2'd2
  } state_e;

endpackage

// File: rtl/divclk_period_meter_sync_rise_detect.sv
// Synchronizer plus rising-edge detector for the asynchronous divided clock.
// The synced level is exported only when DIVCLK_METER_DUTY_MEAS_EN is defined.
module sync_rise_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sig_in,
`ifdef DIVCLK_METER_DUTY_MEAS_EN
  output logic synced,
`endif
  output logic rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_dly;
  logic                   w_synced;

  assign w_synced = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
      r_dly  <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], sig_in};
      r_dly  <= w_synced;
    end
  end

  assign rise = w_synced & ~r_dly;

`ifdef DIVCLK_METER_DUTY_MEAS_EN
  assign synced = w_synced;
`endif

endmodule

// File: rtl/divclk_period_meter.sv
// Measures the period of the divided clock in clk cycles, with timeout.
// DIVCLK_METER_DUTY_MEAS_EN adds a high-time measurement on high_out.
//
// state      | meaning
// ST_IDLE    | waiting for start
// ST_ARM     | waiting for the first rising edge
// ST_MEASURE | counting until the next rising edge
module divclk_period_meter
  import divclk_meter_pkg::*;
#(
  parameter int               CNT_W       = DEF_CNT_W,
  parameter int               SYNC_STAGES = 2,
  parameter logic [CNT_W-1:0] TIMEOUT_CYC = CNT_W'(134217727)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             start,
  input  logic             continuous,
  output logic             busy,
  output logic [CNT_W-1:0] period_out,
  output logic             period_valid,
  output logic             timeout,
  output logic [CNT_W-1:0] high_out
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_period;
  logic             r_valid;
  logic             r_timeout;
  logic             w_rise;
  logic             w_tc;

`ifdef DIVCLK_METER_DUTY_MEAS_EN
  logic             w_synced;
`endif

  sync_rise_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .rst    (rst),
    .sig_in (sig_in),
`ifdef DIVCLK_METER_DUTY_MEAS_EN
    .synced (w_synced),
`endif
    .rise   (w_rise)
  );

  assign w_tc = (r_cnt == TIMEOUT_CYC);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_period  <= '0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state   <= ST_ARM;
            r_cnt     <= '0;
            r_timeout <= 1'b0;
          end
        end
        ST_ARM: begin
          if (w_rise) begin
            r_state <= ST_MEASURE;
            r_cnt   <= ONE;
          end else if (w_tc) begin
            r_state   <= ST_IDLE;
            r_timeout <= 1'b1;
          end else begin
            r_cnt <= r_cnt + ONE;
          end
        end
        ST_MEASURE: begin
          // A rise on the terminal-count cycle still completes the measurement.
          if (w_rise) begin
            r_period <= r_cnt;
            r_valid  <= 1'b1;
            r_cnt    <= ONE;
            if (!continuous) r_state <= ST_IDLE;
          end else if (w_tc) begin
            r_state   <= ST_IDLE;
            r_timeout <= 1'b1;
          end else begin
            r_cnt <= r_cnt + ONE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef DIVCLK_METER_DUTY_MEAS_EN
  logic [CNT_W-1:0] r_hcnt;
  logic [CNT_W-1:0] r_high;

  // The rise cycle is already high, so it is the first counted cycle of the new period.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hcnt <= '0;
      r_high <= '0;
    end else if (r_state == ST_ARM && w_rise) begin
      r_hcnt <= ONE;
    end else if (r_state == ST_MEASURE) begin
      if (w_rise) begin
        r_high <= r_hcnt;
        r_hcnt <= ONE;
      end else if (w_synced) begin
        r_hcnt <= r_hcnt + ONE;
      end
    end
  end

  assign high_out = r_high;
`else
  assign high_out = '0;
`endif

  assign busy         = (r_state != ST_IDLE);
  assign period_out   = r_period;
  assign period_valid = r_valid;
  assign timeout      = r_timeout;

endmodule
